// File: rtl/instr_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
// Single-beat reads: req/addr held until a one-cycle ack carrying data.
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;

  modport master (output req, output addr, input ack, input data);
  modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: fetches the word at decode's PC and holds it until consumed.
// Optional bus timeout is enabled by defining INSTR_FETCH_TIMEOUT_EN.
module instr_fetch #(
  parameter logic [31:0] NOOP           = 32'h00000013,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_EN,
  input  logic [31:0]        i_PC,
  instr_fetch_if.master      ibus,
  output logic               o_INSTRUCTION_VALID,
  output logic [31:0]        o_INSTRUCTION,
  output logic [31:0]        o_FETCH_PC,
  output logic               o_FETCH_ERR
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0] state;
  logic       consume;
  logic       redirect;
  logic       hit;
  logic       aligned;
  logic       timed_out;

  assign consume  = o_INSTRUCTION_VALID & i_EN;
  assign redirect = (i_PC != o_FETCH_PC);
  assign hit      = (ibus.addr == i_PC);
  assign aligned  = (i_PC[1:0] == 2'b00);

`ifdef INSTR_FETCH_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt;
  logic [7:0] wait_cnt_nxt;

  assign wait_cnt_nxt = wait_cnt + 8'd1;
  assign timed_out    = ibus.req & ~ibus.ack & (wait_cnt_nxt == TO_LIMIT);

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      wait_cnt <= 8'd0;
    end else if ((state == S_REQ) && !ibus.req) begin
      wait_cnt <= 8'd0;
    end else if (ibus.req && !ibus.ack) begin
      wait_cnt <= wait_cnt_nxt;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign timed_out      = 1'b0;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  // Within S_REQ, req=0 marks the entry cycle where i_PC is sampled and the
  // request is issued; this is also where a stale fetch gets re-issued.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state               <= S_IDLE;
      ibus.req            <= 1'b0;
      ibus.addr           <= 32'd0;
      o_INSTRUCTION_VALID <= 1'b0;
      o_INSTRUCTION       <= NOOP;
      o_FETCH_PC          <= 32'd0;
      o_FETCH_ERR         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_REQ;

        S_REQ: begin
          if (!ibus.req) begin
            if (aligned) begin
              ibus.req  <= 1'b1;
              ibus.addr <= i_PC;
            end else begin
              o_INSTRUCTION       <= NOOP;
              o_FETCH_PC          <= i_PC;
              o_FETCH_ERR         <= 1'b1;
              o_INSTRUCTION_VALID <= 1'b1;
              state               <= S_HOLD;
            end
          end else if (ibus.ack) begin
            ibus.req <= 1'b0;
            // A response for an address decode has moved away from is dropped.
            if (hit) begin
              o_INSTRUCTION       <= ibus.data;
              o_FETCH_PC          <= ibus.addr;
              o_FETCH_ERR         <= 1'b0;
              o_INSTRUCTION_VALID <= 1'b1;
              state               <= S_HOLD;
            end
          end else if (timed_out) begin
            ibus.req            <= 1'b0;
            o_INSTRUCTION       <= NOOP;
            o_FETCH_PC          <= ibus.addr;
            o_FETCH_ERR         <= 1'b1;
            o_INSTRUCTION_VALID <= 1'b1;
            state               <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (redirect || consume) begin
            o_INSTRUCTION_VALID <= 1'b0;
            o_INSTRUCTION       <= NOOP;
            state               <= S_REQ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios then a randomized run
// against a memory/decode reference model.
module tb_instr_fetch;

  localparam logic [31:0] NOOP = 32'h00000013;

  logic        i_CLK = 1'b0;
  logic        i_RST;
  logic        i_EN;
  logic [31:0] i_PC;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_fpc;
  logic        o_err;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch_if bus();

  instr_fetch #(.NOOP(NOOP), .TIMEOUT_CYCLES(4)) dut (
    .i_CLK               (i_CLK),
    .i_RST               (i_RST),
    .i_EN                (i_EN),
    .i_PC                (i_PC),
    .ibus                (bus),
    .o_INSTRUCTION_VALID (o_valid),
    .o_INSTRUCTION       (o_instr),
    .o_FETCH_PC          (o_fpc),
    .o_FETCH_ERR         (o_err)
  );

  always #5 i_CLK = ~i_CLK;

  // Memory contents are a fixed hash of the address.
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] v;
    v = 32'($urandom_range(0, 1023)) << 2;
    if ($urandom_range(0, 9) == 0) v[1:0] = 2'($urandom_range(1, 3));
    return v;
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    if ((pc[1:0] != 2'b00) || ($urandom_range(0, 9) == 0)) return rand_pc();
    return pc + 32'd4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_CLK);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.req && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.req), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(bus.req), 32'd0);
    chk({tag, "_addr"},  bus.addr,     32'd0);
    chk({tag, "_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_instr"}, o_instr,      NOOP);
    chk({tag, "_fpc"},   o_fpc,        32'd0);
    chk({tag, "_err"},   32'(o_err),   32'd0);
  endtask

  task automatic chk_word(input string tag, input logic [31:0] instr,
                          input logic [31:0] fpc, input logic err);
    chk({tag, "_valid"}, 32'(o_valid), 32'd1);
    chk({tag, "_instr"}, o_instr,      instr);
    chk({tag, "_fpc"},   o_fpc,        fpc);
    chk({tag, "_err"},   32'(o_err),   32'(err));
  endtask

  // Decode consumes the held word; its PC advances at the same edge.
  task automatic consume_to(input logic [31:0] new_pc);
    i_EN = 1'b1;
    tick();
    i_PC = new_pc;
    i_EN = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_RST    = 1'b1;
    i_EN     = 1'b0;
    i_PC     = 32'd0;
    bus.ack  = 1'b0;
    bus.data = 32'd0;
    tick();
    tick();
    chk_reset("reset");
    i_RST = 1'b0;

    // First fetch, zero-wait bus.
    wait_req("first_req");
    chk("first_addr", bus.addr, 32'd0);
    chk("first_valid_low", 32'(o_valid), 32'd0);
    bus.ack  = 1'b1;
    bus.data = 32'h00500093;
    tick();
    bus.ack = 1'b0;
    chk_word("first", 32'h00500093, 32'd0, 1'b0);
    chk("first_req_drop", 32'(bus.req), 32'd0);

    // Decode stalled: word held, no bus activity.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", 32'(o_valid), 32'd1);
      chk("stall_instr", o_instr, 32'h00500093);
      chk("stall_req", 32'(bus.req), 32'd0);
    end
    consume_to(32'd4);
    chk("consumed_valid", 32'(o_valid), 32'd0);
    chk("consumed_instr", o_instr, NOOP);
    tick();
    chk("req4_rise", 32'(bus.req), 32'd1);
    chk("req4_addr", bus.addr, 32'd4);
    bus.ack  = 1'b1;
    bus.data = mem(32'd4);
    tick();
    bus.ack = 1'b0;
    chk_word("word4", mem(32'd4), 32'd4, 1'b0);

    // Stale response: PC jumps during a slow fetch.
    consume_to(32'd8);
    tick();
    chk("req8_addr", bus.addr, 32'd8);
    tick();
    chk("wait1_addr", bus.addr, 32'd8);
    i_PC = 32'h100;
    tick();
    chk("wait2_addr", bus.addr, 32'd8);
    tick();
    chk("wait3_req", 32'(bus.req), 32'd1);
    chk("wait3_addr", bus.addr, 32'd8);
    bus.ack  = 1'b1;
    bus.data = mem(32'd8);
    tick();
    bus.ack  = 1'b0;
    bus.data = 32'hFFFF_FFFF;
    chk("stale_valid", 32'(o_valid), 32'd0);
    chk("stale_instr", o_instr, NOOP);
    wait_req("reissue_req");
    chk("reissue_addr", bus.addr, 32'h100);
    bus.ack  = 1'b1;
    bus.data = 32'h0000ABCD;
    tick();
    bus.ack = 1'b0;
    chk_word("word100", 32'h0000ABCD, 32'h100, 1'b0);

    // Misaligned PC: substitute NOOP without touching the bus.
    consume_to(32'h102);
    chk("mis_req0", 32'(bus.req), 32'd0);
    tick();
    chk("mis_req1", 32'(bus.req), 32'd0);
    chk_word("mis", NOOP, 32'h102, 1'b1);

    // Reset during an outstanding request; ack right after is ignored.
    i_PC = 32'h200;
    tick();
    chk("redirect_valid", 32'(o_valid), 32'd0);
    wait_req("req200");
    chk("req200_addr", bus.addr, 32'h200);
    tick();
    i_RST = 1'b1;
    tick();
    chk_reset("midreset");
    i_RST    = 1'b0;
    bus.ack  = 1'b1;
    bus.data = 32'hDEADBEEF;
    tick();
    bus.ack = 1'b0;
    chk("late_ack_valid", 32'(o_valid), 32'd0);
    chk("late_ack_instr", o_instr, NOOP);
    chk("late_ack_req", 32'(bus.req), 32'd0);
    wait_req("req200b");
    chk("req200b_addr", bus.addr, 32'h200);
    bus.ack  = 1'b1;
    bus.data = mem(32'h200);
    tick();
    bus.ack = 1'b0;
    chk_word("word200", mem(32'h200), 32'h200, 1'b0);

    // Silent bus.
    consume_to(32'h300);
    wait_req("req300");
    chk("req300_addr", bus.addr, 32'h300);
`ifdef INSTR_FETCH_TIMEOUT_EN
    begin
      int n = 1;
      tick();
      while (bus.req && n < 20) begin
        n++;
        tick();
      end
      chk("timeout_req_cycles", 32'(n), 32'd4);
      chk("timeout_req_low", 32'(bus.req), 32'd0);
      chk_word("timeout", NOOP, 32'h300, 1'b1);
      bus.ack  = 1'b1;
      bus.data = 32'h1111_2222;
      tick();
      bus.ack = 1'b0;
      chk_word("timeout_lateack", NOOP, 32'h300, 1'b1);
    end
`else
    begin
      int hi = 0;
      for (int i = 0; i < 120; i++) begin
        tick();
        if (bus.req && bus.addr == 32'h300) hi++;
      end
      chk("no_timeout_req_cycles", 32'(hi), 32'd120);
      chk("no_timeout_valid", 32'(o_valid), 32'd0);
      bus.ack  = 1'b1;
      bus.data = mem(32'h300);
      tick();
      bus.ack = 1'b0;
      chk_word("word300", mem(32'h300), 32'h300, 1'b0);
    end
`endif
    consume_to(32'h400);

    // Randomized run: random wait states, stalls, jumps and redirects.
    begin
      bit          busy      = 1'b0;
      bit          do_adv;
      int          wl        = 0;
      int          idle      = 0;
      int          consumed  = 0;
      logic        prev_req  = bus.req;
      logic        prev_ack  = 1'b0;
      logic [31:0] prev_addr = bus.addr;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (prev_req && !prev_ack) begin
          chk("rnd_req_held", 32'(bus.req), 32'd1);
          chk("rnd_addr_stable", bus.addr, prev_addr);
        end
        if (bus.req) chk("rnd_addr_aligned", 32'(bus.addr[1:0]), 32'd0);
        if (o_valid) begin
          chk("rnd_fetch_pc", o_fpc, i_PC);
          chk("rnd_err", 32'(o_err), 32'(o_fpc[1:0] != 2'b00));
          chk("rnd_instr", o_instr, o_err ? NOOP : mem(o_fpc));
          idle = 0;
        end else begin
          chk("rnd_instr_idle", o_instr, NOOP);
          idle++;
        end
        chk("rnd_progress", 32'(idle <= 60), 32'd1);
        if (idle > 60) break;

        prev_req  = bus.req;
        prev_addr = bus.addr;
        bus.ack   = 1'b0;
        bus.data  = $urandom;
        if (bus.req) begin
          if (!busy) begin
            busy = 1'b1;
            wl   = $urandom_range(0, 2);
          end
          if (wl == 0) begin
            bus.ack  = 1'b1;
            bus.data = mem(bus.addr);
            busy     = 1'b0;
          end else begin
            wl--;
          end
        end
        prev_ack = bus.ack;
        i_EN     = ($urandom_range(0, 3) != 0);
        do_adv   = o_valid && i_EN;
        if (!do_adv && $urandom_range(0, 19) == 0) i_PC = rand_pc();
        tick();
        if (do_adv) begin
          consumed++;
          i_PC = next_pc(i_PC);
        end
      end
      chk("rnd_throughput", 32'(consumed >= 300), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
